// File: rtl/paramest_nn_div_29s_13ns_16_seq.sv
// Sequential signed-by-unsigned restoring divider for the ParamEst_NN datapath.
// It rescales a 29-bit signed accumulator by a 13-bit unsigned scale into a
// saturated 16-bit signed quotient. The quotient truncates toward zero. The
// remainder takes the sign of the dividend. One quotient bit is produced per cycle.
//
// Ports:
//   ap_clk       rising-edge clock
//   ap_rst_n     asynchronous active-low reset; aborts any operation in flight
//   in_valid     operands valid            in_ready   block can accept operands
//   dividend     signed dividend           divisor    unsigned divisor
//   out_valid    result valid              out_ready  downstream accepts result
//   quotient     signed, saturated         remainder  signed, |remainder| < divisor
//   overflow     quotient was saturated    div_by_zero divisor was zero
module paramest_nn_div_29s_13ns_16_seq #(
    parameter int unsigned DIVIDEND_WIDTH = 29,
    parameter int unsigned DIVISOR_WIDTH  = 13,
    parameter int unsigned QUOT_WIDTH     = 16
) (
    input  logic                      ap_clk,
    input  logic                      ap_rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DIVIDEND_WIDTH-1:0] dividend,
    input  logic [DIVISOR_WIDTH-1:0]  divisor,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [QUOT_WIDTH-1:0]     quotient,
    output logic [DIVISOR_WIDTH:0]    remainder,
    output logic                      overflow,
    output logic                      div_by_zero
);

    localparam int unsigned CntWidth = $clog2(DIVIDEND_WIDTH);
    localparam logic [CntWidth-1:0] LastCnt = CntWidth'(DIVIDEND_WIDTH - 1);
    // Largest magnitudes representable in the signed quotient.
    localparam logic [DIVIDEND_WIDTH-1:0] PosLim = DIVIDEND_WIDTH'((1 << (QUOT_WIDTH - 1)) - 1);
    localparam logic [DIVIDEND_WIDTH-1:0] NegLim = DIVIDEND_WIDTH'(1 << (QUOT_WIDTH - 1));
    localparam logic [QUOT_WIDTH-1:0] QMax = {1'b0, {(QUOT_WIDTH - 1){1'b1}}};
    localparam logic [QUOT_WIDTH-1:0] QMin = {1'b1, {(QUOT_WIDTH - 1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e state_q, state_d;

    logic                      sign_q;
    logic                      zero_q;
    logic [DIVIDEND_WIDTH-1:0] mag_q;
    logic [DIVISOR_WIDTH-1:0]  div_q;
    logic [DIVISOR_WIDTH-1:0]  part_q;
    logic [DIVIDEND_WIDTH-2:0] quo_q;
    logic [CntWidth-1:0]       cnt_q;
    logic [QUOT_WIDTH-1:0]     quotient_q;
    logic [DIVISOR_WIDTH:0]    remainder_q;
    logic                      overflow_q;
    logic                      dbz_q;

    logic [DIVIDEND_WIDTH-1:0] abs_dividend;
    logic [DIVISOR_WIDTH:0]    shifted;
    logic [DIVISOR_WIDTH-1:0]  diff;
    logic                      take;
    logic [DIVISOR_WIDTH-1:0]  part_nxt;
    logic [DIVIDEND_WIDTH-1:0] quo_nxt;
    logic [QUOT_WIDTH-1:0]     sat_quot;
    logic                      sat_ovf;
    logic [DIVISOR_WIDTH:0]    rem_fin;

    // Two's-complement magnitude; the most negative dividend maps to 2^(W-1) unsigned.
    assign abs_dividend = dividend[DIVIDEND_WIDTH-1] ? (~dividend + 1'b1) : dividend;

    // One restoring step. The partial remainder is always < divisor. The shifted value
    // therefore needs a single extra bit. The low bits of the difference are exact when take=1.
    always_comb begin
        shifted  = {part_q, mag_q[DIVIDEND_WIDTH-1]};
        take     = (shifted >= {1'b0, div_q});
        diff     = shifted[DIVISOR_WIDTH-1:0] - div_q;
        part_nxt = take ? diff : shifted[DIVISOR_WIDTH-1:0];
        quo_nxt  = {quo_q, take};
    end

    // Sign application and saturation of the final step's result.
    always_comb begin
        sat_quot = '0;
        sat_ovf  = 1'b0;
        if (!sign_q) begin
            if (quo_nxt > PosLim) begin
                sat_quot = QMax;
                sat_ovf  = 1'b1;
            end else begin
                sat_quot = quo_nxt[QUOT_WIDTH-1:0];
            end
        end else begin
            if (quo_nxt > NegLim) begin
                sat_quot = QMin;
                sat_ovf  = 1'b1;
            end else begin
                sat_quot = ~quo_nxt[QUOT_WIDTH-1:0] + 1'b1;
            end
        end
        rem_fin = sign_q ? (~{1'b0, part_nxt} + 1'b1) : {1'b0, part_nxt};
    end

    // FSM state register.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state. A zero divisor spends exactly one cycle in BUSY. Its result
    // therefore appears one edge after acceptance.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (in_valid) state_d = StBusy;
            StBusy: if (zero_q || (cnt_q == LastCnt)) state_d = StDone;
            StDone: if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs.
    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StDone);
    end

    // Datapath and result registers.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            sign_q      <= 1'b0;
            zero_q      <= 1'b0;
            mag_q       <= '0;
            div_q       <= '0;
            part_q      <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            overflow_q  <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        sign_q <= dividend[DIVIDEND_WIDTH-1];
                        zero_q <= (divisor == '0);
                        mag_q  <= abs_dividend;
                        div_q  <= divisor;
                        part_q <= '0;
                        quo_q  <= '0;
                        cnt_q  <= '0;
                    end
                end
                StBusy: begin
                    if (zero_q) begin
                        quotient_q  <= sign_q ? QMin : QMax;
                        remainder_q <= '0;
                        overflow_q  <= 1'b0;
                        dbz_q       <= 1'b1;
                    end else begin
                        part_q <= part_nxt;
                        quo_q  <= quo_nxt[DIVIDEND_WIDTH-2:0];
                        mag_q  <= {mag_q[DIVIDEND_WIDTH-2:0], 1'b0};
                        cnt_q  <= cnt_q + 1'b1;
                        if (cnt_q == LastCnt) begin
                            quotient_q  <= sat_quot;
                            remainder_q <= rem_fin;
                            overflow_q  <= sat_ovf;
                            dbz_q       <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign overflow    = overflow_q;
    assign div_by_zero = dbz_q;

endmodule
